byte_serializer_tx: RTL and testbench
=====================================

// Module: byte_serializer_tx
// PURPOSE
//  Transmit side of the serial byte link into TOP. Buffers bytes from a local producer,
//  then shifts each byte out LSB-first as data bit + write strobe, paced by the
//  receiver's status line, and pulses enqueue once the receiver reports the byte complete.
//  Sits beside TOP on clock_1MHz; its serial outputs drive TOP data_in/write_in/enqueue_in.
// PARAMETERS
//  FIFO_DEPTH   4      input byte buffer entries (power of 2, >=2)
//  START_DELAY  10     cycles from status_in seen high to first bit strobe
//  BIT_HOLD     10     cycles write_out held high per bit
//  BIT_GAP      10     cycles write_out held low after each bit
//  DONE_TIMEOUT 1000   max cycles waiting for status_in low after bit 7
// PORTS
//  clock_1MHz   in   1  system clock, 1 MHz
//  rst          in   1  asynchronous, active-low reset
//  byte_in      in   8  byte to send
//  load_in      in   1  push byte_in into buffer (one push per high cycle)
//  full_out     out  1  buffer full
//  busy_out     out  1  buffer non-empty or transfer in progress
//  ovf_out      out  1  sticky: push attempted while full
//  err_out      out  1  sticky: DONE_TIMEOUT expired
//  status_in    in   1  receiver ready (high) / byte received (low)
//  data_out     out  1  serial bit to receiver
//  write_out    out  1  bit strobe to receiver
//  enqueue_out  out  1  one-cycle commit pulse to receiver
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM IDLE, buffer flushed, counters 0, sticky
//   flags cleared. Reset mid-byte abandons the byte; no enqueue pulse is produced.
//  Buffer: FIFO, wrap-around pointers + count. Push when full dropped, ovf_out<=1.
//   Push and pop in same cycle while full: both succeed, count unchanged.
//  FSM (all outputs registered; state advances on rising clock_1MHz):
//   IDLE      : buffer non-empty -> WAIT_RDY.
//   WAIT_RDY  : status_in==1 -> pop head into shift reg, bit_idx<=0, cnt<=0 -> START.
//   START     : count START_DELAY cycles -> BIT_HI.
//   BIT_HI    : data_out=shift[bit_idx], write_out=1 for BIT_HOLD cycles -> BIT_LO.
//   BIT_LO    : write_out=0, data_out held, BIT_GAP cycles; bit_idx==7 -> WAIT_DONE,
//               else bit_idx+1 -> BIT_HI.
//   WAIT_DONE : status_in==0 -> ENQ; DONE_TIMEOUT cycles elapse -> err_out<=1, byte
//               discarded, -> IDLE (no enqueue).
//   ENQ       : enqueue_out=1 exactly one cycle -> IDLE.
//  data_out/write_out change only on BIT_HI entry/exit; data_out stable whole strobe.
//  status_in dropping during START/BIT_* ignored; only sampled in WAIT_RDY/WAIT_DONE.
//  Per-byte cost: 1 + START_DELAY + 8*(BIT_HOLD+BIT_GAP) + done wait + 1 cycles
//   (defaults: 172 + wait). busy_out=1 from first push until IDLE with empty buffer.
//  Counters sized $clog2(max param)+1; no width truncation at defaults.
// TESTING
//  1 Reset: rst=0 mid BIT_HI -> write_out,data_out,enqueue_out=0 same time, buffer empty.
//  2 Push 8'h99, status_in=1 -> write_out pulses 8x (10 hi/10 lo), data_out seq
//    1,0,0,1,1,0,0,1; status_in->0 -> enqueue_out single 1-cycle pulse; TOP data_out=8'h99.
//  3 Push 5 bytes while status_in=0 -> full_out after 4th, ovf_out=1, bytes 1-4 sent
//    in order once status_in toggles, 5th never sent.
//  4 status_in held 1 after bit 7 -> err_out=1 at 1000 cycles, no enqueue, next byte sent.
//  5 Push while full and WAIT_RDY pop same cycle -> accepted, ovf_out stays 0.
//  6 Back-to-back 8'h00,8'hFF with TOP loopback -> dequeue yields 8'h00 then 8'hFF.

Source files
------------

// File: rtl/byte_serializer_tx.sv
// Transmit side of the serial byte link: buffers producer bytes, then shifts each one out
// LSB-first as data bit + write strobe and commits it with a one-cycle enqueue pulse.
//
// state     | meaning
// IDLE      | nothing in flight; leave as soon as the buffer holds a byte
// WAIT_RDY  | waiting for receiver ready (status_in high); pops head into shift reg
// START     | START_DELAY cycles before the first strobe
// BIT_HI    | data_out = current bit, write_out high for BIT_HOLD cycles
// BIT_LO    | write_out low for BIT_GAP cycles, data_out held
// WAIT_DONE | waiting for status_in low, bounded by DONE_TIMEOUT
// ENQ       | one-cycle enqueue_out commit pulse
module byte_serializer_tx #(
   parameter int FIFO_DEPTH   = 4,
   parameter int START_DELAY  = 10,
   parameter int BIT_HOLD     = 10,
   parameter int BIT_GAP      = 10,
   parameter int DONE_TIMEOUT = 1000
) (
   input  logic       clock_1MHz,
   input  logic       rst,
   input  logic [7:0] byte_in,
   input  logic       load_in,
   output logic       full_out,
   output logic       busy_out,
   output logic       ovf_out,
   output logic       err_out,
   input  logic       status_in,
   output logic       data_out,
   output logic       write_out,
   output logic       enqueue_out
);

   localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CTW   = PW + 1;
   localparam int MAX_A = (START_DELAY > BIT_HOLD) ? START_DELAY : BIT_HOLD;
   localparam int MAX_B = (BIT_GAP > DONE_TIMEOUT) ? BIT_GAP : DONE_TIMEOUT;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_P) + 1;

   typedef enum logic [2:0] {
      IDLE, WAIT_RDY, START, BIT_HI, BIT_LO, WAIT_DONE, ENQ
   } state_t;

   state_t          state_q, state_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic [2:0]      bit_idx_q, bit_idx_n;
   logic [7:0]      shift_q;
   logic            pop, err_set, push_ok;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CTW-1:0]  count_q;

   assign full_out = (count_q == CTW'(FIFO_DEPTH));
   assign busy_out = (count_q != '0) || (state_q != IDLE);
   // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
   assign push_ok  = load_in && (!full_out || pop);

   always_ff @(posedge clock_1MHz) begin
      if (push_ok) mem[wr_ptr_q] <= byte_in;
   end

   always_ff @(posedge clock_1MHz or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_out  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CTW'(1);
            2'b01:   count_q <= count_q - CTW'(1);
            default: count_q <= count_q;
         endcase
         if (load_in && !push_ok) ovf_out <= 1'b1;
      end
   end

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      bit_idx_n = bit_idx_q;
      pop       = 1'b0;
      err_set   = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) state_n = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (status_in) begin
               pop       = 1'b1;
               bit_idx_n = 3'd0;
               cnt_n     = CW'(START_DELAY - 1);
               state_n   = START;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               cnt_n   = CW'(BIT_HOLD - 1);
               state_n = BIT_HI;
            end else begin
               cnt_n = cnt_q - CW'(1);
            end
         end
         BIT_HI: begin
            if (cnt_q == '0) begin
               cnt_n   = CW'(BIT_GAP - 1);
               state_n = BIT_LO;
            end else begin
               cnt_n = cnt_q - CW'(1);
            end
         end
         BIT_LO: begin
            if (cnt_q != '0) begin
               cnt_n = cnt_q - CW'(1);
            end else if (bit_idx_q == 3'd7) begin
               cnt_n   = CW'(DONE_TIMEOUT - 1);
               state_n = WAIT_DONE;
            end else begin
               bit_idx_n = bit_idx_q + 3'd1;
               cnt_n     = CW'(BIT_HOLD - 1);
               state_n   = BIT_HI;
            end
         end
         WAIT_DONE: begin
            if (!status_in) begin
               state_n = ENQ;
            end else if (cnt_q == '0) begin
               err_set = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt_q - CW'(1);
            end
         end
         ENQ: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_1MHz or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         write_out   <= 1'b0;
         data_out    <= 1'b0;
         enqueue_out <= 1'b0;
         err_out     <= 1'b0;
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         bit_idx_q   <= bit_idx_n;
         if (pop) shift_q <= mem[rd_ptr_q];
         write_out   <= (state_n == BIT_HI);
         enqueue_out <= (state_n == ENQ);
         // data_out only moves on BIT_HI entry so it is stable across the whole strobe.
         if (state_n == BIT_HI && state_q != BIT_HI) data_out <= shift_q[bit_idx_n];
         if (err_set) err_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_byte_serializer_tx.sv
// Bench for byte_serializer_tx: a receiver model rebuilds bytes from the strobes and
// a scoreboard queue holds the bytes the producer side expects to arrive.
`timescale 1ns/1ps
module tb_byte_serializer_tx;

   localparam int START_DELAY  = 10;
   localparam int BIT_HOLD     = 10;
   localparam int BIT_GAP      = 10;
   localparam int DONE_TIMEOUT = 1000;

   logic       clock_1MHz = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       load_in = 1'b0;
   logic       full_out, busy_out, ovf_out, err_out;
   logic       status_in, data_out, write_out, enqueue_out;

   logic       status_man = 1'b0;
   logic       status_auto;
   logic       rx_mode = 1'b0;
   assign status_in = rx_mode ? status_auto : status_man;

   byte_serializer_tx #(
      .FIFO_DEPTH(4), .START_DELAY(START_DELAY), .BIT_HOLD(BIT_HOLD),
      .BIT_GAP(BIT_GAP), .DONE_TIMEOUT(DONE_TIMEOUT)
   ) dut (
      .clock_1MHz(clock_1MHz), .rst(rst), .byte_in(byte_in), .load_in(load_in),
      .full_out(full_out), .busy_out(busy_out), .ovf_out(ovf_out), .err_out(err_out),
      .status_in(status_in), .data_out(data_out), .write_out(write_out),
      .enqueue_out(enqueue_out)
   );

   always #500 clock_1MHz = ~clock_1MHz;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Receiver model: samples on the falling edge, rebuilds bytes, measures strobe timing.
   logic       prev_w, prev_enq, prev_err, data_at_rise;
   logic [3:0] bit_cnt;
   logic [7:0] rx_byte;
   int         hi_run, lo_run;
   int         unstable = 0;
   int         enq_double = 0;
   int         enq_cnt = 0;
   int         hold_q[$];
   int         gap_q[$];
   logic [7:0] rx_q[$];

   always @(negedge clock_1MHz) begin
      if (!rst) begin
         prev_w      <= 1'b0;
         prev_enq    <= 1'b0;
         prev_err    <= 1'b0;
         bit_cnt     <= 4'd0;
         hi_run      <= 0;
         lo_run      <= 0;
         status_auto <= 1'b1;
      end else begin
         prev_w   <= write_out;
         prev_enq <= enqueue_out;
         prev_err <= err_out;
         if (write_out && !prev_w) begin
            data_at_rise <= data_out;
            hi_run       <= 1;
            if (bit_cnt == 4'd0 || bit_cnt >= 4'd8) begin
               rx_byte <= {7'b0, data_out};
               bit_cnt <= 4'd1;
            end else begin
               rx_byte[bit_cnt[2:0]] <= data_out;
               bit_cnt <= bit_cnt + 4'd1;
               gap_q.push_back(lo_run);
               if (bit_cnt == 4'd7) status_auto <= 1'b0;
            end
         end else if (write_out) begin
            hi_run <= hi_run + 1;
            if (data_out !== data_at_rise) unstable <= unstable + 1;
         end else if (prev_w) begin
            hold_q.push_back(hi_run);
            lo_run <= 1;
         end else begin
            lo_run <= lo_run + 1;
         end
         if (enqueue_out) begin
            rx_q.push_back(rx_byte);
            enq_cnt     <= enq_cnt + 1;
            bit_cnt     <= 4'd0;
            status_auto <= 1'b1;
            if (prev_enq) enq_double <= enq_double + 1;
         end
         if (err_out && !prev_err) status_auto <= 1'b1;
      end
   end

   logic [7:0] exp_q[$];
   int         rx_rd = 0;

   task automatic tick();
      @(posedge clock_1MHz);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit expect_rx);
      byte_in = b;
      load_in = 1'b1;
      tick();
      load_in = 1'b0;
      if (expect_rx) exp_q.push_back(b);
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k = 0;
      while (rx_q.size() < rx_rd + n && k < budget) begin
         tick();
         k++;
      end
      check_eq("rx_wait", rx_q.size() >= rx_rd + n, 1);
   endtask

   task automatic drain();
      logic [7:0] e;
      while (exp_q.size() > 0 && rx_rd < rx_q.size()) begin
         e = exp_q.pop_front();
         check_eq("rx_byte", rx_q[rx_rd], e);
         rx_rd++;
      end
      check_eq("exp_left", exp_q.size(), 0);
      check_eq("rx_extra", rx_q.size() - rx_rd, 0);
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, s, hb, gb, e0;

      repeat (3) tick();
      check_eq("rst_write", write_out, 0);
      check_eq("rst_data", data_out, 0);
      check_eq("rst_enq", enqueue_out, 0);
      check_eq("rst_flags", {full_out, busy_out, ovf_out, err_out}, 0);
      @(negedge clock_1MHz);
      rst = 1'b1;
      tick();

      // single byte 8'h99 with a cooperating receiver
      rx_mode = 1'b1;
      hb = hold_q.size();
      gb = gap_q.size();
      push_byte(8'h99, 1);
      check_eq("busy_push", busy_out, 1);
      k = 0;
      while (!write_out && k < 100) begin
         tick();
         k++;
      end
      check_eq("first_strobe_lat", k, 2 + START_DELAY);
      wait_rx(1, 400);
      drain();
      check_eq("hold_cnt", hold_q.size() - hb, 8);
      check_eq("gap_cnt", gap_q.size() - gb, 7);
      for (int i = hb; i < hold_q.size(); i++) check_eq("bit_hold", hold_q[i], BIT_HOLD);
      for (int i = gb; i < gap_q.size(); i++) check_eq("bit_gap", gap_q[i], BIT_GAP);
      check_eq("data_stable", unstable, 0);
      check_eq("enq_width", enq_double, 0);
      repeat (3) tick();
      check_eq("busy_idle", busy_out, 0);

      // fill while the receiver is busy, then overflow
      rx_mode    = 1'b0;
      status_man = 1'b0;
      push_byte(8'h11, 1);
      push_byte(8'h22, 1);
      push_byte(8'h33, 1);
      check_eq("full_at3", full_out, 0);
      push_byte(8'h44, 1);
      check_eq("full_at4", full_out, 1);
      check_eq("ovf_before", ovf_out, 0);
      push_byte(8'h55, 0);
      check_eq("ovf_after", ovf_out, 1);
      check_eq("full_kept", full_out, 1);
      e0 = enq_cnt;
      repeat (20) tick();
      check_eq("held_by_status", enq_cnt - e0, 0);
      rx_mode = 1'b1;
      wait_rx(4, 1000);
      drain();
      k = 0;
      while (busy_out && k < 300) begin
         tick();
         k++;
      end
      check_eq("busy_drained", busy_out, 0);
      repeat (300) tick();
      check_eq("no_fifth", rx_q.size() - rx_rd, 0);
      check_eq("ovf_sticky", ovf_out, 1);

      // asynchronous reset in the middle of a strobe
      e0 = enq_cnt;
      push_byte(8'hFF, 0);
      k = 0;
      while (!write_out && k < 100) begin
         tick();
         k++;
      end
      check_eq("pre_rst_write", write_out, 1);
      #300;
      rst = 1'b0;
      #1;
      check_eq("arst_write", write_out, 0);
      check_eq("arst_data", data_out, 0);
      check_eq("arst_enq", enqueue_out, 0);
      check_eq("arst_flags", {full_out, busy_out, ovf_out, err_out}, 0);
      repeat (2) @(negedge clock_1MHz);
      rst = 1'b1;
      repeat (200) tick();
      check_eq("arst_no_enq", enq_cnt - e0, 0);
      check_eq("arst_busy", busy_out, 0);

      // push into a full buffer on the same edge WAIT_RDY pops
      rx_mode    = 1'b0;
      status_man = 1'b0;
      push_byte(8'hA1, 1);
      push_byte(8'hB2, 1);
      push_byte(8'hC3, 1);
      push_byte(8'hD4, 1);
      check_eq("full_pre_pop", full_out, 1);
      rx_mode = 1'b1;
      push_byte(8'hE5, 1);
      check_eq("ovf_pushpop", ovf_out, 0);
      check_eq("full_pushpop", full_out, 1);
      wait_rx(5, 1300);
      drain();

      // back-to-back extremes
      push_byte(8'h00, 1);
      push_byte(8'hFF, 1);
      wait_rx(2, 600);
      drain();

      // receiver never reports completion
      rx_mode    = 1'b0;
      status_man = 1'b1;
      hb = hold_q.size();
      e0 = enq_cnt;
      push_byte(8'hA5, 0);
      k = 0;
      while (hold_q.size() < hb + 8 && k < 400) begin
         @(negedge clock_1MHz);
         #1;
         k++;
      end
      check_eq("to_bits_sent", hold_q.size() - hb, 8);
      s = 0;
      while (!err_out && s < 1200) begin
         @(negedge clock_1MHz);
         #1;
         s++;
      end
      check_eq("err_latency", s, BIT_GAP + DONE_TIMEOUT);
      check_eq("err_set", err_out, 1);
      check_eq("to_no_enq", enq_cnt - e0, 0);
      tick();
      rx_mode = 1'b1;
      push_byte(8'h3C, 1);
      wait_rx(1, 400);
      drain();
      check_eq("err_sticky", err_out, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
